// File: rtl/mux4_scan.sv
// mux4_scan: sequencer for a 4:1 bit mux. Steps the select through
// channels a, b, c, d, holds each select for SETTLE cycles, samples the
// mux output at the end of each hold and presents the packed 4-bit word
// downstream with a valid/ready handshake.
// Optional build macro MUX4_SCAN_CONT_EN: a start seen on the handshake
// edge in DONE launches the next scan directly, without passing through IDLE.
module mux4_scan #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       mux_in,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [1:0] ch, ch_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] work, work_n;
  logic [1:0] sel_n;
  logic [3:0] data_n;
  logic       valid_n;
  logic       busy_n;

  // Channel index to mux select: a=00, b=10, c=01, d=11 (bit-reversed index).
  function automatic logic [1:0] enc(input logic [1:0] c);
    return {c[0], c[1]};
  endfunction

  // State and output registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
      cnt   <= '0;
      work  <= '0;
      sel   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      cnt   <= cnt_n;
      work  <= work_n;
      sel   <= sel_n;
      data  <= data_n;
      valid <= valid_n;
      busy  <= busy_n;
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    work_n  = work;
    sel_n   = sel;
    data_n  = data;
    valid_n = valid;
    busy_n  = busy;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SETTLE;
          ch_n    = '0;
          sel_n   = enc(2'd0);
          cnt_n   = '0;
          work_n  = '0;
          busy_n  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          cnt_n      = '0;
          work_n[ch] = mux_in;
          if (ch != 2'd3) begin
            ch_n  = ch + 2'd1;
            sel_n = enc(ch + 2'd1);
          end else begin
            // Last channel: its bit goes straight into the output word on
            // the same edge it is captured.
            data_n  = {mux_in, work[2:0]};
            valid_n = 1'b1;
            busy_n  = 1'b0;
            state_n = S_DONE;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (ready) begin
          valid_n = 1'b0;
`ifdef MUX4_SCAN_CONT_EN
          if (start) begin
            state_n = S_SETTLE;
            ch_n    = '0;
            sel_n   = enc(2'd0);
            cnt_n   = '0;
            work_n  = '0;
            busy_n  = 1'b1;
          end else begin
            state_n = S_IDLE;
            sel_n   = '0;
          end
`else
          state_n = S_IDLE;
          sel_n   = '0;
`endif
        end
      end
      default: begin
        state_n = S_IDLE;
        sel_n   = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mux4_scan.md
Name: mux4_scan

Overview:
- Upstream controller for the 4:1 mux (`mux4`). It drives the mux select, steps through the four channels a, b, c and d, and samples the mux output once per channel.
- It packs the four samples into a 4-bit word and presents that word downstream with a valid/ready handshake.
- This turns the combinational mux into a sequenced 4-channel bit sampler for the datapath.

Parameters:
- SETTLE, 1, cycles each select value is held before its sample is taken. Legal range 1..15; the counter is 4 bits wide.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request one scan; sampled only in IDLE
- sel  output  2  select to mux4 `s`; channel encoding a=2'b00, b=2'b10, c=2'b01, d=2'b11
- mux_in  input  1  mux4 output
- data  output  4  scanned word; data[0]=a, data[1]=b, data[2]=c, data[3]=d
- valid  output  1  data holds a completed scan
- ready  input  1  consumer accepts data
- busy  output  1  scan in progress (SETTLE state)

Behaviour:
- Reset, asynchronous and active-high, forces:
  - state=IDLE
  - sel=2'b00, data=4'h0, valid=0, busy=0
  - internal ch=0, cnt=0, work=4'h0
- Reset asserted mid-scan or during DONE aborts immediately. There is no partial output.
- States are IDLE, SETTLE and DONE, registered. All outputs are registered. There is no combinational path from inputs to outputs.
- IDLE:
  - start=1 at an edge → SETTLE, ch=0, sel=enc(0), cnt=0, work=0, busy=1.
  - start=0 → stay in IDLE.
- SETTLE:
  - Each edge does cnt++.
  - At the edge where cnt==SETTLE-1, capture work[ch]<=mux_in and set cnt=0.
  - If ch<3: ch++, sel=enc(ch+1), stay in SETTLE.
  - If ch==3: data<=work with bit 3 = mux_in (same edge), valid=1, busy=0 → DONE.
  - sel changes only at channel boundaries and is held constant for exactly SETTLE cycles per channel.
- Latency: if start is sampled at edge E, valid rises after edge E+4*SETTLE.
- DONE:
  - data, valid and sel are held stable while ready=0. There is no timeout.
  - valid&&ready at an edge → valid=0 → IDLE. data keeps its last value.
- start outside IDLE is ignored (unless the optional feature below is enabled). Start requests are neither queued nor counted.
- ready outside DONE is ignored.
- mux_in is sampled only at capture edges; glitches between captures have no effect.
- sel returns to 2'b00 on entering IDLE.

Optional Feature:
- Macro: MUX4_SCAN_CONT_EN.
- Defined: on the handshake edge in DONE, if start=1, the block goes directly to SETTLE with ch=0, sel=enc(0), cnt=0, busy=1. This skips IDLE and gives back-to-back scans every 4*SETTLE+1 cycles while start stays high and ready=1. If start=0 at the handshake edge → IDLE.
- Undefined: DONE always returns to IDLE after the handshake, and start is honoured only in IDLE.

Test Plan:
1. Reset: reset=1 at t=0, then released; clock 10 ns → sel=00, data=0000, valid=0, busy=0. Assert reset mid-SETTLE (ch=2) → all outputs return to reset values asynchronously, before the next clock edge.
2. Single scan, SETTLE=1: a=1, b=0, c=1, d=1 behind a mux4 model; pulse start for one cycle.
   - sel sequence 00,10,01,11, one cycle each.
   - valid after 4 edges.
   - data=4'b1101, busy high for 4 cycles.
3. Backpressure: same scan with ready=0 for 10 cycles after valid → data=1101, valid=1, sel=11 stable for all 10 cycles. ready=1 → valid=0 next edge, state IDLE.
4. SETTLE=3: inputs a=0, b=1, c=0, d=0.
   - Each sel value is held exactly 3 cycles.
   - Change a to 1 during the first 2 cycles of channel a and back to 0 before its capture edge → data=4'b0010.
   - valid after 12 edges.
5. Ignored start: pulse start during SETTLE and again during DONE → exactly one scan is produced; after the handshake the block stays in IDLE.
6. Continuous mode (MUX4_SCAN_CONT_EN, SETTLE=1): hold start=1 and ready=1.
   - valid pulses every 5 cycles with a fresh data word each time.
   - Drop start before a handshake → that handshake returns the block to IDLE and no further scans run.
